// File: rtl/exhaustive_pattern_sequencer_if.sv
// Record stream carrying one (pattern, response) pair per swept input pattern.
interface exhaustive_pattern_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
);
  logic             rec_valid;
  logic             rec_ready;
  logic [N_IN-1:0]  rec_pattern;
  logic [N_OUT-1:0] rec_response;

  modport master (output rec_valid, output rec_pattern, output rec_response, input rec_ready);
  modport slave  (input rec_valid, input rec_pattern, input rec_response, output rec_ready);
endinterface

// File: rtl/exhaustive_pattern_sequencer.sv
// Sweeps every input pattern into a benchmark DUT, samples each response after a
// settle delay, streams (pattern, response) records and folds responses into a signature.
module exhaustive_pattern_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                           CK,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  output logic [N_IN-1:0]                dut_in,
  input  logic [N_OUT-1:0]               dut_out,
  exhaustive_pattern_sequencer_if.master rec,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    sig
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_t;

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [N_IN-1:0]  r_pattern;
  logic [N_IN-1:0]  r_rec_pattern;
  logic [N_OUT-1:0] r_rec_response;
  logic             r_rec_valid;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_sig;

  logic [15:0]      w_sig_next;
  logic             w_last;

  assign w_sig_next = {r_sig[14:0], r_sig[15]} ^ 16'(dut_out);
  assign w_last     = &r_pattern;

  always_ff @(posedge CK) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_pattern      <= '0;
      r_rec_pattern  <= '0;
      r_rec_response <= '0;
      r_rec_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sig          <= '0;
    end else if (abort) begin
      // Abort beats both start (in IDLE) and a pending handshake; signature is kept.
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pattern   <= '0;
      r_rec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_WAIT;
            r_pattern <= '0;
            r_cnt     <= '0;
            r_sig     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_rec_response <= dut_out;
            r_rec_pattern  <= r_pattern;
            r_sig          <= w_sig_next;
            r_rec_valid    <= 1'b1;
            r_state        <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (rec.rec_ready) begin
            r_rec_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_pattern <= r_pattern + 1'b1;
              r_cnt     <= '0;
              r_state   <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_pattern <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_in           = r_pattern;
  assign rec.rec_valid    = r_rec_valid;
  assign rec.rec_pattern  = r_rec_pattern;
  assign rec.rec_response = r_rec_response;
  assign busy             = r_busy;
  assign done             = r_done;
  assign sig              = r_sig;

endmodule

// File: tb/tb_exhaustive_pattern_sequencer.sv
// Randomized bench: swept records, signature and timing compared to a pattern-level model.
module tb_exhaustive_pattern_sequencer;

  logic        CK = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  dut_in;
  logic [3:0]  dut_out;
  logic        busy, done;
  logic [15:0] sig;

  logic        start3, abort3;
  logic [3:0]  dut_in3;
  logic [0:0]  dut_out3;
  logic        busy3, done3;
  logic [15:0] sig3;
  logic        d1, d2;

  int          errors = 0;
  int          checks = 0;
  int          mode;
  logic [3:0]  rtab [16];

  always #5 CK = ~CK;

  exhaustive_pattern_sequencer_if #(.N_IN(4), .N_OUT(4)) rif ();
  exhaustive_pattern_sequencer_if #(.N_IN(4), .N_OUT(1)) rif3 ();

  exhaustive_pattern_sequencer #(.N_IN(4), .N_OUT(4), .SETTLE(1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .rec(rif.master),
    .busy(busy), .done(done), .sig(sig)
  );

  exhaustive_pattern_sequencer #(.N_IN(4), .N_OUT(1), .SETTLE(3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .abort(abort3),
    .dut_in(dut_in3), .dut_out(dut_out3), .rec(rif3.master),
    .busy(busy3), .done(done3), .sig(sig3)
  );

  // Benchmark DUT models: combinational for the main instance, 2-cycle delayed LSB for the other.
  always_comb begin
    case (mode)
      0:       dut_out = {3'b000, ^dut_in};
      1:       dut_out = 4'd1;
      2:       dut_out = 4'd0;
      default: dut_out = rtab[dut_in];
    endcase
  end

  always @(posedge CK) begin
    d1 <= dut_in3[0];
    d2 <= d1;
  end
  assign dut_out3 = d2;

  function automatic logic [3:0] ref_resp(input int p);
    case (mode)
      0:       return 4'($countones(p & 15) % 2);
      1:       return 4'd1;
      2:       return 4'd0;
      default: return rtab[p & 15];
    endcase
  endfunction

  function automatic logic [15:0] ref_sig(input int last);
    int s = 0;
    for (int i = 0; i <= last; i++) begin
      s = ((s << 1) | (s >> 15)) & 'hFFFF;
      s = s ^ int'(ref_resp(i));
    end
    return 16'(s);
  endfunction

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (dut_in !== 4'd0 || rif.rec_valid !== 1'b0 || rif.rec_pattern !== 4'd0 ||
        rif.rec_response !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || sig !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got in=%0h v=%0b pat=%0h resp=%0h busy=%0b done=%0b sig=%0h expected all zero",
               dut_in, rif.rec_valid, rif.rec_pattern, rif.rec_response, busy, done, sig);
    end
    checks++;
    if (dut_in3 !== 4'd0 || rif3.rec_valid !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0 || sig3 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state3: got in=%0h v=%0b busy=%0b done=%0b sig=%0h expected all zero",
               dut_in3, rif3.rec_valid, busy3, done3, sig3);
    end
  endtask

  // Full sweep with random rec_ready stalls and optional start pokes while busy.
  task automatic run_sweep(input string name, input int stall_pct, input bit poke_start);
    int k, stalls;
    bit seen_done, stalled_prev;
    logic [3:0] hold_pat, hold_in, hold_resp;
    logic [3:0] pats[$];
    logic [3:0] resps[$];
    k = 0; stalls = 0; seen_done = 0; stalled_prev = 0;
    hold_pat = '0; hold_in = '0; hold_resp = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dut_in !== 4'd0 || sig !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: got busy=%0b in=%0h sig=%0h done=%0b expected 1 0 0 0", name, busy, dut_in, sig, done);
    end
    while (k < 2000) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy: got %0b expected 1 at cycle %0d", name, busy, k);
      end
      if (stalled_prev) begin
        checks++;
        if (rif.rec_valid !== 1'b1 || rif.rec_pattern !== hold_pat || dut_in !== hold_in ||
            rif.rec_response !== hold_resp) begin
          errors++;
          $display("FAIL %s_stall_hold: got v=%0b pat=%0h in=%0h resp=%0h expected 1 %0h %0h %0h",
                   name, rif.rec_valid, rif.rec_pattern, dut_in, rif.rec_response, hold_pat, hold_in, hold_resp);
        end
      end
      rif.rec_ready = ($urandom_range(99) >= stall_pct);
      start = poke_start && ($urandom_range(7) == 0);
      stalled_prev = 0;
      if (rif.rec_valid) begin
        if (rif.rec_ready) begin
          pats.push_back(rif.rec_pattern);
          resps.push_back(rif.rec_response);
        end else begin
          stalls++;
          stalled_prev = 1;
          hold_pat = rif.rec_pattern;
          hold_in = dut_in;
          hold_resp = rif.rec_response;
        end
      end
      tick;
      k++;
    end
    start = 1'b0;
    rif.rec_ready = 1'b1;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", name);
    end
    checks++;
    if (k != 32 + stalls) begin
      errors++;
      $display("FAIL %s_done_time: got %0d expected %0d", name, k, 32 + stalls);
    end
    checks++;
    if (pats.size() != 16) begin
      errors++;
      $display("FAIL %s_rec_count: got %0d expected 16", name, pats.size());
    end
    for (int p = 0; p < 16 && p < pats.size(); p++) begin
      checks++;
      if (pats[p] !== 4'(p) || resps[p] !== ref_resp(p)) begin
        errors++;
        $display("FAIL %s_record%0d: got pat=%0h resp=%0h expected pat=%0h resp=%0h",
                 name, p, pats[p], resps[p], p, ref_resp(p));
      end
    end
    checks++;
    if (sig !== ref_sig(15)) begin
      errors++;
      $display("FAIL %s_sig: got %0h expected %0h", name, sig, ref_sig(15));
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dut_in !== 4'd0 || rif.rec_valid !== 1'b0 || sig !== ref_sig(15)) begin
      errors++;
      $display("FAIL %s_after: got done=%0b busy=%0b in=%0h v=%0b sig=%0h expected 0 0 0 0 %0h",
               name, done, busy, dut_in, rif.rec_valid, sig, ref_sig(15));
    end
  endtask

  task automatic test_parity;
    mode = 0;
    run_sweep("parity", 0, 0);
  endtask

  task automatic test_const;
    mode = 1;
    run_sweep("const1", 0, 0);
    checks++;
    if (sig !== 16'hFFFF) begin
      errors++;
      $display("FAIL const1_sig_ffff: got %0h expected ffff", sig);
    end
    mode = 2;
    run_sweep("const0", 0, 0);
  endtask

  task automatic test_back_to_back;
    mode = 3;
    for (int i = 0; i < 16; i++) rtab[i] = 4'($urandom_range(15));
    run_sweep("stall", 40, 1);
    for (int i = 0; i < 16; i++) rtab[i] = 4'($urandom_range(15));
    run_sweep("stall2", 60, 1);
  endtask

  task automatic test_settle3;
    int k, first_valid;
    bit seen_done;
    int s;
    logic [3:0] pats[$];
    logic [0:0] resps[$];
    k = 0; first_valid = -1; seen_done = 0;
    rif3.rec_ready = 1'b1;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    while (k < 500) begin
      if (done3) begin
        seen_done = 1;
        break;
      end
      if (rif3.rec_valid) begin
        if (first_valid < 0) first_valid = k;
        pats.push_back(rif3.rec_pattern);
        resps.push_back(rif3.rec_response);
      end
      tick;
      k++;
    end
    checks++;
    if (!seen_done || k != 64) begin
      errors++;
      $display("FAIL settle3_done_time: got %0d (seen=%0b) expected 64", k, seen_done);
    end
    checks++;
    if (first_valid != 3) begin
      errors++;
      $display("FAIL settle3_first_valid: got %0d expected 3", first_valid);
    end
    checks++;
    if (pats.size() != 16) begin
      errors++;
      $display("FAIL settle3_rec_count: got %0d expected 16", pats.size());
    end
    for (int p = 0; p < 16 && p < pats.size(); p++) begin
      checks++;
      if (pats[p] !== 4'(p) || resps[p] !== 1'(p & 1)) begin
        errors++;
        $display("FAIL settle3_record%0d: got pat=%0h resp=%0h expected %0h %0h", p, pats[p], resps[p], p, p & 1);
      end
    end
    s = 0;
    for (int p = 0; p < 16; p++) s = (((s << 1) | (s >> 15)) & 'hFFFF) ^ (p & 1);
    checks++;
    if (sig3 !== 16'(s)) begin
      errors++;
      $display("FAIL settle3_sig: got %0h expected %0h", sig3, 16'(s));
    end
  endtask

  task automatic test_abort;
    int k;
    bit found;
    logic [15:0] exp5;
    mode = 3;
    for (int i = 0; i < 16; i++) rtab[i] = 4'($urandom_range(15));
    exp5 = ref_sig(5);
    k = 0; found = 0;
    rif.rec_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (k < 200) begin
      if (rif.rec_valid && rif.rec_pattern == 4'd5) begin
        found = 1;
        break;
      end
      tick;
      k++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach5: got no pattern 5 record expected one within 200 cycles");
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rif.rec_valid !== 1'b0 || dut_in !== 4'd0 || done !== 1'b0 || sig !== exp5) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b v=%0b in=%0h done=%0b sig=%0h expected 0 0 0 0 %0h",
               busy, rif.rec_valid, dut_in, done, sig, exp5);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sig !== exp5) begin
        errors++;
        $display("FAIL abort_hold: got done=%0b busy=%0b sig=%0h expected 0 0 %0h", done, busy, sig, exp5);
      end
    end
    run_sweep("restart", 20, 0);
  endtask

  task automatic test_abort_start_idle;
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || dut_in !== 4'd0 || rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: got busy=%0b in=%0h v=%0b expected 0 0 0", busy, dut_in, rif.rec_valid);
    end
  endtask

  task automatic test_reset_midrun;
    int k;
    bit found;
    mode = 0;
    k = 0; found = 0;
    rif.rec_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (k < 200) begin
      if (rif.rec_valid && rif.rec_pattern == 4'd9) begin
        found = 1;
        break;
      end
      tick;
      k++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach9: got no pattern 9 record expected one within 200 cycles");
    end
    reset = 1'b1;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (dut_in !== 4'd0 || rif.rec_valid !== 1'b0 || rif.rec_pattern !== 4'd0 ||
        rif.rec_response !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || sig !== 16'd0) begin
      errors++;
      $display("FAIL reset_midrun: got in=%0h v=%0b pat=%0h resp=%0h busy=%0b done=%0b sig=%0h expected all zero",
               dut_in, rif.rec_valid, rif.rec_pattern, rif.rec_response, busy, done, sig);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || rif.rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: got busy=%0b v=%0b expected 0 0", busy, rif.rec_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start3 = 1'b0;
    abort3 = 1'b0;
    mode = 0;
    rif.rec_ready = 1'b0;
    rif3.rec_ready = 1'b0;
    for (int i = 0; i < 16; i++) rtab[i] = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    test_reset;
    test_parity;
    test_const;
    test_back_to_back;
    test_settle3;
    test_abort;
    test_abort_start_idle;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
